// File: rtl/iter_div_pkg.sv
// Shared definitions for the iterative divider and the EX-stage div_op decode.
// Holds div_op bit positions, op width, the divider FSM state encoding and a
// one-hot helper used to reject malformed op vectors.
package iter_div_pkg;

  localparam int DIV_OP_W      = 4;
  localparam int DIV_OP_DIV_W  = 0;
  localparam int DIV_OP_MOD_W  = 1;
  localparam int DIV_OP_DIV_WU = 2;
  localparam int DIV_OP_MOD_WU = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  function automatic logic op_is_onehot(input logic [DIV_OP_W-1:0] op);
    int ones;
    ones = 0;
    for (int i = 0; i < DIV_OP_W; i++) begin
      ones += int'(op[i]);
    end
    return (ones == 1);
  endfunction

endpackage

// File: rtl/iter_div_if.sv
// Request/response bundle between EX (master) and the divider (slave).
// Request: req_valid/req_ready with div_op, x (dividend), y (divisor).
// Response: resp_valid/resp_ready with result.
interface iter_div_if #(parameter int WIDTH = 32);
  import iter_div_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [DIV_OP_W-1:0] div_op;
  logic [WIDTH-1:0]    x;
  logic [WIDTH-1:0]    y;
  logic                resp_valid;
  logic                resp_ready;
  logic [WIDTH-1:0]    result;

  modport master (
    output req_valid, div_op, x, y, resp_ready,
    input  req_ready, resp_valid, result
  );

  modport slave (
    input  req_valid, div_op, x, y, resp_ready,
    output req_ready, resp_valid, result
  );

endinterface

// File: rtl/iter_div_step.sv
// One restoring-division step: shift next dividend bit into the partial remainder
// and subtract the divisor if it fits. Purely combinational, no backpressure.
// Ports: rem_in/divisor WIDTH, dvd_bit 1 -> rem_out WIDTH, q_bit 1.
module iter_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  // rem_in < divisor, so the shifted value needs one extra bit for the compare.
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;

  assign trial = {rem_in, dvd_bit};
  assign q_bit = (trial >= {1'b0, divisor});
  // When q_bit is set the true difference is < divisor, so the low bits are exact.
  assign diff    = trial[WIDTH-1:0] - divisor;
  assign rem_out = q_bit ? diff : trial[WIDTH-1:0];

endmodule

// File: rtl/iter_div.sv
// Multi-cycle signed/unsigned divider (div.w/mod.w/div.wu/mod.wu), one quotient bit per cycle.
// Latency: accept at edge n, resp_valid high after edge n+WIDTH+1; single op in flight.
// Backpressure: result held in DONE until resp_ready; req_ready only in IDLE and not in reset.
// Ports: clk, rst (sync, active-high), bus (iter_div_if.slave: req/resp handshakes, div_op, x, y, result).
module iter_div
  import iter_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  iter_div_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  div_state_t          state, state_nxt;
  logic [DIV_OP_W-1:0] op_r;
  logic                sign_q, sign_r, dvs_zero;
  logic [WIDTH-1:0]    dvd;      // dividend magnitude, shifted out MSB-first; quotient shifts in
  logic [WIDTH-1:0]    dvs;      // divisor magnitude
  logic [WIDTH-1:0]    rem;
  logic [WIDTH-1:0]    res;
  logic [CW-1:0]       cnt;

  logic                accept;
  logic                is_signed, sx, sy;
  logic [WIDTH-1:0]    abs_x, abs_y;
  logic [WIDTH-1:0]    rem_step;
  logic                q_step;
  logic [WIDTH-1:0]    q_fix, r_fix, fix_res;

  assign bus.req_ready  = ~rst & (state == IDLE);
  assign bus.resp_valid = (state == DONE);
  assign bus.result     = res;
  assign accept         = bus.req_valid & bus.req_ready;

  // Magnitudes fit in WIDTH bits unsigned, including |most-negative|.
  assign is_signed = bus.div_op[DIV_OP_DIV_W] | bus.div_op[DIV_OP_MOD_W];
  assign sx        = is_signed & bus.x[WIDTH-1];
  assign sy        = is_signed & bus.y[WIDTH-1];
  assign abs_x     = sx ? -bus.x : bus.x;
  assign abs_y     = sy ? -bus.y : bus.y;

  iter_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .dvd_bit (dvd[WIDTH-1]),
    .divisor (dvs),
    .rem_out (rem_step),
    .q_bit   (q_step)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sign fix-up. A zero divisor yields all-ones quotient regardless of signs;
  // the remainder path already reproduces x since the abs/negate round-trips.
  always_comb begin
    q_fix = sign_q ? -dvd : dvd;
    if (dvs_zero) q_fix = '1;
    r_fix   = sign_r ? -rem : rem;
    fix_res = '0;
    if (op_is_onehot(op_r)) begin
      fix_res = (op_r[DIV_OP_DIV_W] | op_r[DIV_OP_DIV_WU]) ? q_fix : r_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_r     <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      dvs_zero <= 1'b0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      res      <= '0;
      cnt      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_r     <= bus.div_op;
            sign_q   <= sx ^ sy;
            sign_r   <= sx;
            dvs_zero <= (bus.y == '0);
            dvd      <= abs_x;
            dvs      <= abs_y;
            rem      <= '0;
            cnt      <= '0;
          end
        end
        CALC: begin
          rem <= rem_step;
          dvd <= {dvd[WIDTH-2:0], q_step};
          cnt <= cnt + CW'(1);
        end
        FIX:     res <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_div.sv
// Self-checking bench for iter_div: directed corner cases plus randomized ops
// checked against an arithmetic reference model (longint divide/modulo).
module tb_iter_div;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  iter_div_if #(.WIDTH(W)) bus ();

  iter_div #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: quotient truncates toward zero, remainder takes dividend sign.
  function automatic logic [31:0] ref_div(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (!(op == 4'b0001 || op == 4'b0010 || op == 4'b0100 || op == 4'b1000)) return 32'h0;
    if (b == 32'h0) return (op[0] | op[2]) ? 32'hFFFF_FFFF : a;
    if (op[0] | op[1]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = {32'h0, a};
      sb = {32'h0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return (op[0] | op[2]) ? q[31:0] : r[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and wait for the accept edge, then scramble inputs.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int t;
    bus.req_valid = 1'b1;
    bus.div_op    = op;
    bus.x         = a;
    bus.y         = b;
    t = 0;
    while (!bus.req_ready && t < 200) begin
      tick();
      t++;
    end
    vectors++;
    if (!bus.req_ready) begin
      miscompares++;
      $display("FAIL accept_timeout: req_ready=%0b required 1", bus.req_ready);
    end
    tick();
    bus.req_valid = 1'b0;
    bus.div_op    = 4'($urandom);
    bus.x         = $urandom;
    bus.y         = $urandom;
  endtask

  // Edges from accept until resp_valid is seen (bounded).
  task automatic wait_resp(output int lat);
    lat = 0;
    while (!bus.resp_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic take_resp();
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int lat;
    issue(op, a, b);
    wait_resp(lat);
    vectors++;
    if (lat !== LAT) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d edges required %0d", name, lat, LAT);
    end
    vectors++;
    if (bus.result !== exp || ref_div(op, a, b) !== exp) begin
      miscompares++;
      $display("FAIL %s_result: got %h required %h (model %h)", name, bus.result, exp, ref_div(op, a, b));
    end
    take_resp();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    vectors++;
    if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0 || bus.result !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state: req_ready=%b resp_valid=%b result=%h required 0 0 0",
               bus.req_ready, bus.resp_valid, bus.result);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: req_ready=%b required 1", bus.req_ready);
    end
    tick();
  endtask

  task automatic test_signed();
    run_op("div_w_neg", 4'b0001, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op("mod_w_neg", 4'b0010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
  endtask

  task automatic test_unsigned();
    run_op("div_wu", 4'b0100, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);
    run_op("mod_wu", 4'b1000, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001);
  endtask

  task automatic test_overflow();
    run_op("div_w_ovf", 4'b0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("mod_w_ovf", 4'b0010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
  endtask

  task automatic test_div_zero();
    run_op("div_w_zero",  4'b0001, 32'd5,        32'd0, 32'hFFFF_FFFF);
    run_op("mod_wu_zero", 4'b1000, 32'd5,        32'd0, 32'h0000_0005);
    run_op("div_wu_zero", 4'b0100, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF);
    run_op("mod_w_negz",  4'b0010, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0);
    run_op("bad_op_zero", 4'b0000, 32'd100,      32'd7, 32'h0);
    run_op("bad_op_multi",4'b0011, 32'd100,      32'd7, 32'h0);
  endtask

  task automatic test_backpressure();
    int lat;
    issue(4'b0001, 32'd1000, 32'hFFFF_FFFD);   // 1000 / -3 = -333
    wait_resp(lat);
    bus.req_valid = 1'b1;
    bus.div_op    = 4'b1000;
    bus.x         = 32'd1000;
    bus.y         = 32'd7;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (bus.resp_valid !== 1'b1 || bus.result !== 32'hFFFF_FEB3 || bus.req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold%0d: resp_valid=%b result=%h req_ready=%b required 1 fffffeb3 0",
                 i, bus.resp_valid, bus.result, bus.req_ready);
      end
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    vectors++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release: req_ready=%b resp_valid=%b required 1 0", bus.req_ready, bus.resp_valid);
    end
    tick();                                     // held request accepted here
    bus.req_valid = 1'b0;
    wait_resp(lat);
    vectors++;
    if (lat !== LAT || bus.result !== ref_div(4'b1000, 32'd1000, 32'd7)) begin
      miscompares++;
      $display("FAIL bp_queued: lat=%0d result=%h required %0d %h", lat, bus.result, LAT,
               ref_div(4'b1000, 32'd1000, 32'd7));
    end
    take_resp();
  endtask

  task automatic test_rst_mid();
    bit seen;
    issue(4'b0001, 32'd12345, 32'd11);
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    vectors++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid: resp_valid=%b req_ready=%b required 0 0", bus.resp_valid, bus.req_ready);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_ready: req_ready=%b required 1", bus.req_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.resp_valid) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL rst_mid_ghost: resp_valid seen=1 required 0");
    end
    run_op("post_rst", 4'b0001, 32'd100, 32'd7, 32'h0000_000E);
  endtask

  task automatic test_random();
    logic [31:0] specials [6];
    logic [3:0]  op;
    logic [31:0] a, b, exp;
    int          lat;
    specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : 32'($urandom >> $urandom_range(0, 31));
      exp = ref_div(op, a, b);
      issue(op, a, b);
      wait_resp(lat);
      vectors++;
      if (lat !== LAT || bus.result !== exp) begin
        miscompares++;
        $display("FAIL rand%0d: op=%b x=%h y=%h lat=%0d result=%h required lat %0d result %h",
                 n, op, a, b, lat, bus.result, LAT, exp);
      end
      take_resp();
    end
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.div_op     = '0;
    bus.x          = '0;
    bus.y          = '0;
    bus.resp_ready = 1'b0;
    test_reset();
    test_signed();
    test_unsigned();
    test_overflow();
    test_div_zero();
    test_backpressure();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
